// File: rtl/transmit.sv
// UART transmitter: serialises a parallel word as start bit, LSB-first data,
// then stop bit(s) on a line that idles high. Pairs with the receive block.
module transmit #(
  parameter int bits        = 8,
  parameter int ticksPerBit = 16,
  parameter int stopBits    = 1
) (
  input  logic            tick,
  input  logic            rstN,
  input  logic            en,
  input  logic            start,
  input  logic [bits-1:0] in,
  output logic            out,
  output logic            done,
  output logic            busy,
  output logic            error,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(ticksPerBit);
  localparam int IW = $clog2(bits);
  localparam logic [CW-1:0] cnt_last  = CW'(ticksPerBit - 1);
  localparam logic [IW-1:0] idx_last  = IW'(bits - 1);
  localparam logic [IW-1:0] stop_last = IW'(stopBits - 1);

  typedef enum logic [1:0] {idle, startBit, dataBits, stopBit} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   idx, idx_n, idx_inc;
  logic [bits-1:0] data, data_n;
  logic            out_n, done_n, busy_n, error_n;

  assign dbg_state = state;
  assign idx_inc   = idx + 1'b1;

  always_ff @(posedge tick or negedge rstN) begin
    if (!rstN) begin
      state <= idle;
      cnt   <= '0;
      idx   <= '0;
      data  <= '0;
      out   <= 1'b1;
      done  <= 1'b0;
      busy  <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      data  <= data_n;
      out   <= out_n;
      done  <= done_n;
      busy  <= busy_n;
      error <= error_n;
    end
  end

  // idx doubles as the stop-bit period counter once the data bits are out.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    data_n  = data;
    out_n   = out;
    busy_n  = busy;
    done_n  = 1'b0;
    error_n = 1'b0;
    case (state)
      idle: begin
        out_n  = 1'b1;
        busy_n = 1'b0;
        if (en && start) begin
          data_n  = in;
          busy_n  = 1'b1;
          out_n   = 1'b0;
          cnt_n   = '0;
          idx_n   = '0;
          state_n = startBit;
        end
      end
      startBit: begin
        if (cnt == cnt_last) begin
          cnt_n   = '0;
          idx_n   = '0;
          out_n   = data[0];
          state_n = dataBits;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      dataBits: begin
        if (cnt == cnt_last) begin
          cnt_n = '0;
          if (idx == idx_last) begin
            idx_n   = '0;
            out_n   = 1'b1;
            state_n = stopBit;
          end else begin
            idx_n = idx_inc;
            out_n = data[idx_inc];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      stopBit: begin
        out_n = 1'b1;
        if (cnt == cnt_last) begin
          cnt_n = '0;
          if (idx == stop_last) begin
            idx_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = idle;
          end else begin
            idx_n = idx_inc;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = idle;
    endcase
    // A request that arrives while a frame is in flight is dropped.
    if (state != idle && start) error_n = 1'b1;
  end

endmodule

// File: tb/tb_transmit.sv
// Directed bench for transmit: frame shape, back-to-back, dropped requests,
// enable gating, async reset and a 7-bit / 2-stop-bit variant.
module tb_transmit;

  logic       tick = 1'b0;
  logic       rstN;
  logic       en, start;
  logic [7:0] in;
  logic       out, done, busy, error;
  logic [1:0] dbg_state;

  logic       en2, start2;
  logic [6:0] in2;
  logic       out2, done2, busy2, error2;
  logic [1:0] dbg_state2;

  int checks = 0;
  int errors = 0;

  transmit #(.bits(8), .ticksPerBit(16), .stopBits(1)) dut (
    .tick(tick), .rstN(rstN), .en(en), .start(start), .in(in),
    .out(out), .done(done), .busy(busy), .error(error), .dbg_state(dbg_state)
  );

  transmit #(.bits(7), .ticksPerBit(4), .stopBits(2)) dut2 (
    .tick(tick), .rstN(rstN), .en(en2), .start(start2), .in(in2),
    .out(out2), .done(done2), .busy(busy2), .error(error2), .dbg_state(dbg_state2)
  );

  always #5 tick = ~tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the next posedge is the accepting edge E0.
  // Negedge j afterwards shows cycle E0+j.
  task automatic run_frame(input string tag, input logic [7:0] w,
                           input int drop_at, input int en_off_at);
    int bad, busy_cnt, done_cnt, done_at, err_cnt, err_at;
    logic [9:0] frame;
    logic       exp_out;
    bad = 0; busy_cnt = 0; done_cnt = 0; done_at = -1; err_cnt = 0; err_at = -1;
    frame = {1'b1, w, 1'b0};
    in = w; en = 1'b1; start = 1'b1;
    @(negedge tick);
    start = 1'b0;
    in = ~w;
    for (int j = 1; j <= 170; j++) begin
      exp_out = (j <= 160) ? frame[(j - 1) / 16] : 1'b1;
      if (out !== exp_out) bad++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
      end
      if (error === 1'b1) begin
        err_cnt++;
        err_at = j;
      end
      start = (j == drop_at);
      en = (en_off_at > 0 && j >= en_off_at) ? 1'b0 : 1'b1;
      @(negedge tick);
    end
    en = 1'b1;
    start = 1'b0;
    check({tag, "_bad_bits"}, bad, 0);
    check({tag, "_busy_cycles"}, busy_cnt, 160);
    check({tag, "_done_at"}, done_at, 161);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_err_cnt"}, err_cnt, (drop_at > 0) ? 1 : 0);
    check({tag, "_err_at"}, err_at, (drop_at > 0) ? drop_at + 1 : -1);
  endtask

  initial begin
    int bad, busy_cnt, done_cnt, err_cnt, done_at1, done_at2;
    logic [9:0] f1, f2;
    logic       exp_out;

    rstN = 1'b0; en = 1'b0; start = 1'b0; in = 8'h00;
    en2 = 1'b0; start2 = 1'b0; in2 = 7'h00;
    repeat (3) @(negedge tick);
    check("rst_out", out, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_state", dbg_state, 0);
    rstN = 1'b1;
    repeat (2) @(negedge tick);

    run_frame("a5", 8'hA5, 0, 0);

    // 0x00 then 0xFF, second request on the done cycle.
    f1 = {1'b1, 8'h00, 1'b0};
    f2 = {1'b1, 8'hFF, 1'b0};
    bad = 0; done_cnt = 0; err_cnt = 0; done_at1 = -1; done_at2 = -1;
    in = 8'h00; en = 1'b1; start = 1'b1;
    @(negedge tick);
    start = 1'b0;
    for (int j = 1; j <= 330; j++) begin
      if (j <= 160)      exp_out = f1[(j - 1) / 16];
      else if (j == 161) exp_out = 1'b1;
      else if (j <= 321) exp_out = f2[(j - 162) / 16];
      else               exp_out = 1'b1;
      if (out !== exp_out) bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at1 < 0) done_at1 = j; else done_at2 = j;
      end
      if (error === 1'b1) err_cnt++;
      start = (j == 161);
      if (j == 161) in = 8'hFF;
      @(negedge tick);
    end
    start = 1'b0;
    check("b2b_bad_bits", bad, 0);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_done_at1", done_at1, 161);
    check("b2b_done_at2", done_at2, 322);
    check("b2b_err_cnt", err_cnt, 0);

    run_frame("drop3c", 8'h3C, 50, 0);

    // en low in idle with start held.
    bad = 0;
    en = 1'b0; start = 1'b1;
    for (int j = 0; j < 100; j++) begin
      @(negedge tick);
      if (out !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) bad++;
    end
    start = 1'b0; en = 1'b1;
    check("en_low_idle", bad, 0);
    @(negedge tick);

    run_frame("en_off", 8'h96, 0, 20);

    // Async reset while data bits are in flight.
    in = 8'hA5; en = 1'b1; start = 1'b1;
    @(negedge tick);
    start = 1'b0;
    repeat (69) @(negedge tick);
    check("pre_rst_out", out, 0);
    check("pre_rst_busy", busy, 1);
    rstN = 1'b0;
    #1;
    check("async_rst_out", out, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_state", dbg_state, 0);
    @(negedge tick);
    rstN = 1'b1;
    @(negedge tick);
    run_frame("post_rst81", 8'h81, 0, 0);

    // 7 data bits, T=4, 2 stop bits.
    bad = 0; busy_cnt = 0; done_cnt = 0; done_at1 = -1; err_cnt = 0;
    f1 = {2'b11, 7'h55, 1'b0};
    in2 = 7'h55; en2 = 1'b1; start2 = 1'b1;
    @(negedge tick);
    start2 = 1'b0;
    in2 = 7'h2A;
    for (int j = 1; j <= 48; j++) begin
      exp_out = (j <= 40) ? f1[(j - 1) / 4] : 1'b1;
      if (out2 !== exp_out) bad++;
      if (busy2 === 1'b1) busy_cnt++;
      if (done2 === 1'b1) begin
        done_cnt++;
        if (done_at1 < 0) done_at1 = j;
      end
      if (error2 === 1'b1) err_cnt++;
      @(negedge tick);
    end
    check("s2_bad_bits", bad, 0);
    check("s2_busy_cycles", busy_cnt, 40);
    check("s2_done_at", done_at1, 41);
    check("s2_done_cnt", done_cnt, 1);
    check("s2_err_cnt", err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/transmit.md
# transmit

Serial asynchronous (UART) transmitter, the transmit-side counterpart of the `receive` block in `uart/rtl`. It accepts a parallel word on a one-cycle request and serialises it onto the line as a frame: a start bit, then data LSB first, then stop bit(s). The frame format, bit order and line idle level match what `receive` expects. It sits between the host-side data source and the TX pin and runs on the same `tick` clock.

## Interface
Parameters:
- `bits`, 8: data bits per frame; legal 5..9.
- `ticksPerBit`, 16: `tick` cycles per bit period; legal ≥2.
- `stopBits`, 1: stop-bit count; legal 1 or 2.

Ports:
- `tick`  input  1  clock; all state updates on posedge.
- `rstN`  input  1  asynchronous, active-low reset.
- `en`  input  1  enable; gates acceptance of new requests only.
- `start`  input  1  transmit request; sampled on each posedge.
- `in`  input  `bits`  data word; captured on the edge that accepts `start`.
- `out`  output  1  serial line; idle high.
- `done`  output  1  one-cycle pulse when a frame completes.
- `busy`  output  1  high while a frame is in flight.
- `error`  output  1  one-cycle pulse when a request is dropped.

## Operation
- Reset (`rstN`=0, asynchronous): `out`=1, `done`=0, `busy`=0, `error`=0, state=idle, counters=0, data register=0. Asserting reset mid-frame truncates the frame immediately. `out` returns high, and the receiver sees a framing error, which is acceptable.
- States:
  - idle: `out`=1. On `en`&`start`, capture `in`, set `busy`<=1, `out`<=0, and go to startBit.
  - startBit: hold `out`=0 for `ticksPerBit` cycles, then go to dataBits.
  - dataBits: drive `data[bitIndex]` for `ticksPerBit` cycles per bit, `bitIndex` 0..`bits`-1, then go to stopBit.
  - stopBit: drive `out`=1 for `stopBits`×`ticksPerBit` cycles, then go to idle with `busy`<=0 and `done`<=1.
- Tick counter width is `$clog2(ticksPerBit)`; bit index width is `$clog2(bits)`. Counters reset to 0 on each bit boundary, and there is no wrap past the terminal count.
- `out` is registered, so there is no combinational path from inputs to `out`.
- `en` low in idle: `start` is ignored and `error` stays low. `en` dropping mid-frame has no effect, and the frame completes.
- `start` while not idle: the request is dropped, `error` pulses for one cycle, and the frame in flight and its captured data are unaffected.
- `in` changes after capture do not affect the frame in flight.

## Timing
- Let E0 be the accepting edge. The start bit occupies cycles E0+1 .. E0+T, where T=`ticksPerBit`.
- Data bit k occupies E0+(1+k)·T+1 .. E0+(2+k)·T.
- Stop begins at edge E0+(1+bits)·T.
- At edge E0+(1+bits+stopBits)·T: state becomes idle, `busy` falls, and `done` rises for exactly one cycle.
- Frame length is (1+`bits`+`stopBits`)·T cycles.
- `busy` is high from E0+1 through the last stop cycle inclusive.
- Back-to-back: the earliest next accept is the edge at which `done` is high (the first idle cycle). The minimum gap between frames is one extra high cycle.
- Latency from `start` to the first start-bit cycle on `out` is 1 cycle.
- `start` on the final stop-bit edge is still a busy request: it is dropped and `error` pulses.
- `done` and `error` never assert in the same cycle except when `start` arrives on the completing edge. In that case both assert, and the request is dropped.

## Test plan
- `bits`=8, T=16, 1 stop, `in`=0xA5, start at E0 -> `out` sequence 0,1,0,1,0,0,1,0,1,1, each held 16 cycles. `busy` is high for 160 cycles. `done` pulses at E0+160.
- Two words 0x00 and 0xFF, with the second `start` asserted on the `done` cycle -> second frame starts one cycle after the first ends. `out` is 0 for 9 bit periods, then 1 for 1, then the second frame shows 0 for 1 bit period and 1 for 9.
- `start` pulsed at E0+50 during a frame carrying 0x3C -> `error` is high for exactly one cycle at E0+51. The 0x3C frame is bit-exact, and there is no second frame.
- `en`=0 with `start`=1 held for 100 cycles -> `out` stays 1, and `busy`, `done` and `error` stay 0. `en` cleared at E0+20 mid-frame -> the frame completes normally.
- `rstN` pulsed low at E0+70 (data bits in flight) -> `out`=1, `busy`=0 and `done`=0 asynchronously, before the next edge. After release, a new 0x81 frame transmits correctly.
- `stopBits`=2, `bits`=7, T=4, `in`=0x55 -> frame of 40 cycles, with the stop level high for 8 cycles before `done`.
